nfc_latch_cycle_sequencer: RTL and testbench

Sequences SDR (asynchronous-interface) command and address latch cycles onto the NAND physical output stage. Accepts one byte per valid/ready beat, tagged as command or address and with a target way, and drives the parallel physical-output bus: CE, CLE, ALE, WE, RE, DQ, DQ output enable, DQS and DQS output enable. CE stays asserted across a multi-beat sequence and is released after the beat flagged last. The block sits between the NAND command engines and the DDR output serialiser.

---
 rtl/nfc_latch_cycle_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_nfc_latch_cycle_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_latch_cycle_sequencer.sv
// SDR command/address latch-cycle sequencer for the NAND physical output stage.
// Each accepted byte becomes one CLE/ALE write cycle; CE spans a multi-beat sequence.
module nfc_latch_cycle_sequencer #(
    parameter int NumberOfWays = 4,
    parameter int SetupCycles  = 2,
    parameter int WELowCycles  = 2,
    parameter int WEHighCycles = 2,
    parameter int HoldCycles   = 2
) (
    input  logic                      iSystemClock,
    input  logic                      iModuleReset,
    input  logic [NumberOfWays-1:0]   iTargetWay,
    input  logic                      iBeatValid,
    output logic                      oBeatReady,
    input  logic                      iBeatIsAddress,
    input  logic [7:0]                iBeatData,
    input  logic                      iBeatLast,
    output logic                      oBusy,
    output logic                      oSequenceDone,
    output logic [7:0]                oPO_DQStrobe,
    output logic [31:0]               oPO_DQ,
    output logic [2*NumberOfWays-1:0] oPO_ChipEnable,
    output logic [3:0]                oPO_ReadEnable,
    output logic [3:0]                oPO_WriteEnable,
    output logic [3:0]                oPO_AddressLatchEnable,
    output logic [3:0]                oPO_CommandLatchEnable,
    output logic                      oDQOutEnable,
    output logic                      oDQSOutEnable
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WE_LOW, S_WE_HIGH, S_WAIT, S_HOLD, S_RELEASE
    } state_t;

    localparam logic [3:0] SetupLoad  = 4'(SetupCycles - 1);
    localparam logic [3:0] WELowLoad  = 4'(WELowCycles - 1);
    localparam logic [3:0] WEHighLoad = 4'(WEHighCycles - 1);
    localparam logic [3:0] HoldLoad   = 4'(HoldCycles - 1);

    state_t                    state_q;
    logic [3:0]                cnt_q;
    logic [NumberOfWays-1:0]   way_q;
    logic                      last_q;
    logic                      ready_q;
    logic                      busy_q;
    logic                      done_q;
    logic [2*NumberOfWays-1:0] ce_q;
    logic                      we_q;
    logic                      cle_q;
    logic                      ale_q;
    logic [7:0]                dq_q;
    logic                      dq_oe_q;

    logic                      accept_d;
    logic [NumberOfWays-1:0]   way_d;

    // The way is only taken from the request on the first beat of a sequence.
    always_comb begin
        accept_d = iBeatValid & ready_q;
        if (state_q == S_IDLE) begin
            way_d = iTargetWay;
        end else begin
            way_d = way_q;
        end
    end

    // Sequencer state, shared down-counter and registered pad outputs.
    always_ff @(posedge iSystemClock) begin
        if (iModuleReset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            way_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ce_q    <= '1;
            we_q    <= 1'b1;
            cle_q   <= 1'b0;
            ale_q   <= 1'b0;
            dq_q    <= 8'h00;
            dq_oe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WAIT: begin
                    ready_q <= 1'b1;
                    if (accept_d) begin
                        state_q <= S_SETUP;
                        cnt_q   <= SetupLoad;
                        way_q   <= way_d;
                        last_q  <= iBeatLast;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        ce_q    <= ~{way_d, way_d};
                        we_q    <= 1'b1;
                        cle_q   <= ~iBeatIsAddress;
                        ale_q   <= iBeatIsAddress;
                        dq_q    <= iBeatData;
                        dq_oe_q <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_WE_LOW;
                        cnt_q   <= WELowLoad;
                        we_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WE_LOW: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_WE_HIGH;
                        cnt_q   <= WEHighLoad;
                        we_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WE_HIGH: begin
                    if (cnt_q == 4'd0) begin
                        cle_q   <= 1'b0;
                        ale_q   <= 1'b0;
                        dq_q    <= 8'h00;
                        dq_oe_q <= 1'b0;
                        if (last_q) begin
                            state_q <= S_HOLD;
                            cnt_q   <= HoldLoad;
                        end else begin
                            state_q <= S_WAIT;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RELEASE;
                        ce_q    <= '1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ce_q    <= '1;
                    we_q    <= 1'b1;
                    cle_q   <= 1'b0;
                    ale_q   <= 1'b0;
                    dq_q    <= 8'h00;
                    dq_oe_q <= 1'b0;
                end
            endcase
        end
    end

    // SDR: every lane of the DDR-capable output stage carries the same value.
    assign oBeatReady             = ready_q;
    assign oBusy                  = busy_q;
    assign oSequenceDone          = done_q;
    assign oPO_DQStrobe           = 8'h00;
    assign oPO_DQ                 = {4{dq_q}};
    assign oPO_ChipEnable         = ce_q;
    assign oPO_ReadEnable         = 4'b1111;
    assign oPO_WriteEnable        = {4{we_q}};
    assign oPO_AddressLatchEnable = {4{ale_q}};
    assign oPO_CommandLatchEnable = {4{cle_q}};
    assign oDQOutEnable           = dq_oe_q;
    assign oDQSOutEnable          = 1'b0;

endmodule

// File: tb/tb_nfc_latch_cycle_sequencer.sv
// Bench for nfc_latch_cycle_sequencer: a cycle-offset model of each beat's
// timeline, checked every cycle, plus directed literal expectations.
module tb_nfc_latch_cycle_sequencer;

    localparam int S  = 2;
    localparam int L  = 2;
    localparam int H  = 2;
    localparam int HC = 2;
    localparam int D  = S + L + H;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  way;
    logic        valid;
    logic        isaddr;
    logic [7:0]  data;
    logic        last;
    logic        rdy, busy, done, oe, dqsoe;
    logic [7:0]  dqs, ce;
    logic [31:0] dq;
    logic [3:0]  re, we, ale, cle;

    logic        v2;
    logic        r2, busy2, done2, oe2, dqsoe2;
    logic [7:0]  dqs2, ce2;
    logic [31:0] dq2;
    logic [3:0]  re2, we2, ale2, cle2;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int mc = 0;

    always #5 clk = ~clk;

    nfc_latch_cycle_sequencer #(
        .NumberOfWays(4), .SetupCycles(S), .WELowCycles(L),
        .WEHighCycles(H), .HoldCycles(HC)
    ) dut (
        .iSystemClock(clk), .iModuleReset(rst), .iTargetWay(way),
        .iBeatValid(valid), .oBeatReady(rdy), .iBeatIsAddress(isaddr),
        .iBeatData(data), .iBeatLast(last), .oBusy(busy), .oSequenceDone(done),
        .oPO_DQStrobe(dqs), .oPO_DQ(dq), .oPO_ChipEnable(ce),
        .oPO_ReadEnable(re), .oPO_WriteEnable(we),
        .oPO_AddressLatchEnable(ale), .oPO_CommandLatchEnable(cle),
        .oDQOutEnable(oe), .oDQSOutEnable(dqsoe)
    );

    nfc_latch_cycle_sequencer #(
        .NumberOfWays(4), .SetupCycles(1), .WELowCycles(1),
        .WEHighCycles(1), .HoldCycles(1)
    ) dut2 (
        .iSystemClock(clk), .iModuleReset(rst), .iTargetWay(4'b0001),
        .iBeatValid(v2), .oBeatReady(r2), .iBeatIsAddress(1'b0),
        .iBeatData(8'h3C), .iBeatLast(1'b0), .oBusy(busy2), .oSequenceDone(done2),
        .oPO_DQStrobe(dqs2), .oPO_DQ(dq2), .oPO_ChipEnable(ce2),
        .oPO_ReadEnable(re2), .oPO_WriteEnable(we2),
        .oPO_AddressLatchEnable(ale2), .oPO_CommandLatchEnable(cle2),
        .oDQOutEnable(oe2), .oDQSOutEnable(dqsoe2)
    );

    // Model: outputs are a function of the edge offset d since the last accept.
    bit         m_act;
    bit         m_last, m_addr;
    logic [3:0] m_way;
    logic [7:0] m_byte;
    int         m_a, d;
    logic [7:0] e_ce, e_dq;
    logic       e_we, e_cle, e_ale, e_oe, e_rdy, e_busy, e_done;

    always @(posedge clk) begin
        mc++;
        if (rst) begin
            m_act = 1'b0;
            e_ce = 8'hFF; e_we = 1'b1; e_cle = 1'b0; e_ale = 1'b0; e_dq = 8'h00;
            e_oe = 1'b0; e_rdy = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            if (valid && e_rdy) begin
                if (!m_act) begin
                    m_way = way;
                    m_act = 1'b1;
                end
                m_byte = data; m_addr = isaddr; m_last = last; m_a = mc;
            end
            e_done = 1'b0; e_cle = 1'b0; e_ale = 1'b0; e_dq = 8'h00; e_oe = 1'b0; e_we = 1'b1;
            if (!m_act) begin
                e_ce = 8'hFF; e_rdy = 1'b1; e_busy = 1'b0;
            end else begin
                d = mc - m_a;
                e_ce = ~{m_way, m_way}; e_busy = 1'b1; e_rdy = 1'b0;
                if (d < D) begin
                    e_cle = !m_addr; e_ale = m_addr; e_dq = m_byte; e_oe = 1'b1;
                    e_we = !(d >= S && d < S + L);
                end else if (!m_last) begin
                    e_rdy = 1'b1;
                end else if (d == D + HC) begin
                    e_ce = 8'hFF;
                end else if (d > D + HC) begin
                    m_act = 1'b0; e_ce = 8'hFF; e_rdy = 1'b1; e_busy = 1'b0; e_done = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s @%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mc > 0) begin
            if (done === 1'b1) done_cnt++;
            chk("ce",    {24'h0, ce},   {24'h0, e_ce});
            chk("we",    {28'h0, we},   {28'h0, {4{e_we}}});
            chk("cle",   {28'h0, cle},  {28'h0, {4{e_cle}}});
            chk("ale",   {28'h0, ale},  {28'h0, {4{e_ale}}});
            chk("dq",    dq,            {4{e_dq}});
            chk("dq_oe", {31'h0, oe},   {31'h0, e_oe});
            chk("ready", {31'h0, rdy},  {31'h0, e_rdy});
            chk("busy",  {31'h0, busy}, {31'h0, e_busy});
            chk("done",  {31'h0, done}, {31'h0, e_done});
            chk("re",    {28'h0, re},   32'h0000000F);
            chk("dqs",   {24'h0, dqs, 7'h0, dqsoe}, 32'h0);
        end
    end

    task automatic send(input logic [3:0] w, input logic a, input logic [7:0] b,
                        input logic l, output int acc);
        int n;
        n = 0;
        way = w; isaddr = a; data = b; last = l; valid = 1'b1;
        while (rdy !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            chk("accept_timeout", 32'd0, 32'd1);
            valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1 acc = mc;
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt - base, 32'd1);
    endtask

    initial begin
        int a, prev, base, wl;
        int acc2[$];
        rst = 1'b1; way = 4'h0; valid = 1'b0; isaddr = 1'b0; data = 8'h00; last = 1'b0;
        v2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce",    {24'h0, ce}, 32'h000000FF);
        chk("rst_we",    {28'h0, we}, 32'h0000000F);
        chk("rst_ready", {31'h0, rdy}, 32'h0);
        chk("rst_oe",    {31'h0, oe}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, rdy}, 32'h1);

        // Single command 0x70 to way 1.
        base = done_cnt;
        send(4'b0010, 1'b0, 8'h70, 1'b1, a);
        chk("t2_ce",  {24'h0, ce}, 32'h000000DD);
        chk("t2_cle", {28'h0, cle}, 32'h0000000F);
        chk("t2_dq",  dq, 32'h70707070);
        repeat (2) @(negedge clk);
        chk("t2_we_low", {28'h0, we}, 32'h0);
        wait_done(base);

        // Command then five address beats, valid held between beats.
        base = done_cnt;
        send(4'b0001, 1'b0, 8'h00, 1'b0, prev);
        for (int i = 0; i < 5; i++) begin
            send(4'b0001, 1'b1, 8'h10 + 8'(i), (i == 4), a);
            if (i == 0) begin
                chk("t3_ale", {28'h0, ale}, 32'h0000000F);
                chk("t3_cle", {28'h0, cle}, 32'h0);
            end
            chk("t3_period", a - prev, 32'd7);
            prev = a;
        end
        wait_done(base);

        // Way change on the second beat must be ignored.
        base = done_cnt;
        send(4'b0001, 1'b0, 8'h90, 1'b0, prev);
        send(4'b1000, 1'b1, 8'hAB, 1'b1, a);
        chk("t4_way_kept", {24'h0, ce}, 32'h000000EE);
        chk("t4_period", a - prev, 32'd7);
        wait_done(base);

        // Multi-hot and all-zero way selects.
        base = done_cnt;
        send(4'b0101, 1'b0, 8'h31, 1'b1, a);
        chk("t4_multi_ce", {24'h0, ce}, 32'h000000AA);
        wait_done(base);
        base = done_cnt;
        send(4'b0000, 1'b1, 8'h05, 1'b1, a);
        chk("t4_zero_ce", {24'h0, ce}, 32'h000000FF);
        wait_done(base);

        // Reset during WE_LOW aborts without a done pulse.
        base = done_cnt;
        send(4'b0100, 1'b0, 8'hFF, 1'b0, a);
        repeat (2) @(negedge clk);
        chk("t5_we_low", {28'h0, we}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_we", {28'h0, we}, 32'h0000000F);
        chk("t5_ce", {24'h0, ce}, 32'h000000FF);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_no_done", done_cnt - base, 32'd0);

        // Minimum timing instance: 4-cycle period, one-cycle WE low.
        wl = 0;
        v2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (r2 === 1'b1) acc2.push_back(i);
            if (we2 === 4'h0) wl++;
            @(negedge clk);
        end
        v2 = 1'b0;
        chk("t6_accepts", acc2.size(), 32'd4);
        for (int i = 1; i < acc2.size(); i++) begin
            chk("t6_period", acc2[i] - acc2[i-1], 32'd4);
        end
        chk("t6_we_low_cycles", wl, 32'd4);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
